sprite_plot_arbiter: RTL and testbench

Shares the single VGA pixel-plot port (x, y, colour, plot) between up to N_REQ sprite controllers: player, enemies and bullets.
Each requester asks to draw or erase one SPRITE_W x SPRITE_H box at a base coordinate. The arbiter grants requesters in round-robin order, walks the box one pixel per clock, and pulses done back to the winner.
It sits between the sprite control FSMs and the vga_adapter, and replaces their private pixel counters.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_plot_arbiter_if.sv | 27 ++
 rtl/box_pixel_counter.sv | 66 ++++++
 rtl/sprite_plot_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sprite_plot_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite/VGA constants, arbiter state encoding and the latched job payload.
package sprite_pkg;

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned COL_W = 3;

    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;
    localparam int unsigned DEF_SPRITE_W = 10;
    localparam int unsigned DEF_SPRITE_H = 10;

    localparam logic [COL_W-1:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } sprite_job_t;

endpackage

// File: rtl/sprite_plot_arbiter_if.sv
// Requester-side and VGA-side signals of the sprite plot arbiter.
interface sprite_plot_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]                    req;
    logic [sprite_pkg::X_W*N_REQ-1:0]    req_x;
    logic [sprite_pkg::Y_W*N_REQ-1:0]    req_y;
    logic [sprite_pkg::COL_W*N_REQ-1:0]  req_colour;
    logic [N_REQ-1:0]                    req_erase;
    logic [N_REQ-1:0]                    grant;
    logic [N_REQ-1:0]                    done;
    logic [sprite_pkg::X_W-1:0]          vga_x;
    logic [sprite_pkg::Y_W-1:0]          vga_y;
    logic [sprite_pkg::COL_W-1:0]        vga_colour;
    logic                                vga_plot;
    logic                                busy;

    modport master (
        output req, req_x, req_y, req_colour, req_erase,
        input  grant, done, vga_x, vga_y, vga_colour, vga_plot, busy
    );

    modport slave (
        input  req, req_x, req_y, req_colour, req_erase,
        output grant, done, vga_x, vga_y, vga_colour, vga_plot, busy
    );
endinterface

// File: rtl/box_pixel_counter.sv
// Walks a SPRITE_W x SPRITE_H box row-major and reports the next pixel address
// and whether it falls on the visible screen.
module box_pixel_counter
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H = DEF_SPRITE_H,
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    output logic [X_W-1:0] pix_x_c,
    output logic [Y_W-1:0] pix_y_c,
    output logic           on_screen_c,
    output logic           last_c
);
    localparam int unsigned CX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned CY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPRITE_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPRITE_H - 1);

    logic [CX_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0] cy_q, cy_d;

    // Next column/row: restart on start, otherwise advance row-major on step.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step) begin
            if (cx_q == CX_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == CY_LAST) ? '0 : cy_q + CY_W'(1);
            end else begin
                cx_d = cx_q + CX_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    // Address of the pixel the counters are moving to, with screen clipping.
    always_comb begin
        pix_x_c     = base_x + X_W'(cx_d);
        pix_y_c     = base_y + Y_W'(cy_d);
        on_screen_c = (32'(pix_x_c) < SCREEN_W) && (32'(pix_y_c) < SCREEN_H);
        last_c      = (cx_q == CX_LAST) && (cy_q == CY_LAST);
    end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// Round-robin arbiter sharing the single VGA plot port between sprite controllers;
// the winner's box is walked one pixel per clock and done is pulsed at the end.
module sprite_plot_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned SPRITE_W = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H = DEF_SPRITE_H,
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_plot_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  last_q, last_d;
    sprite_job_t       job_q, job_d;

    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [X_W-1:0]    vga_x_q, vga_x_d;
    logic [Y_W-1:0]    vga_y_q, vga_y_d;
    logic [COL_W-1:0]  vga_colour_q, vga_colour_d;
    logic              vga_plot_q, vga_plot_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              cnt_start;
    logic              cnt_step;
    logic [X_W-1:0]    pix_x_c;
    logic [Y_W-1:0]    pix_y_c;
    logic              on_screen_c;
    logic              last_c;

    logic [X_W-1:0]    req_x_arr   [N_REQ];
    logic [Y_W-1:0]    req_y_arr   [N_REQ];
    logic [COL_W-1:0]  req_col_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_x_arr[g]   = bus.req_x[g*X_W +: X_W];
        assign req_y_arr[g]   = bus.req_y[g*Y_W +: Y_W];
        assign req_col_arr[g] = bus.req_colour[g*COL_W +: COL_W];
    end

    // Round-robin select: first pending requester after the last winner.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(last_q) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic: latch the winner's job in IDLE, walk the box, then report done.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        job_d     = job_q;
        cnt_start = 1'b0;
        cnt_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    win_d        = pick;
                    job_d.x      = req_x_arr[pick];
                    job_d.y      = req_y_arr[pick];
                    job_d.colour = bus.req_erase[pick] ? COLOUR_BLACK : req_col_arr[pick];
                    cnt_start    = 1'b1;
                    state_d      = ST_DRAW;
                end
            end
            ST_DRAW: begin
                cnt_step = 1'b1;
                if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    box_pixel_counter #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .start       (cnt_start),
        .step        (cnt_step),
        .base_x      (job_d.x),
        .base_y      (job_d.y),
        .pix_x_c     (pix_x_c),
        .pix_y_c     (pix_y_c),
        .on_screen_c (on_screen_c),
        .last_c      (last_c)
    );

    // Output decode from next-state values so every output is a flop.
    always_comb begin
        grant_d      = (state_d == ST_DRAW) ? (N_REQ'(1) << win_d) : '0;
        done_d       = (state_d == ST_DONE) ? (N_REQ'(1) << win_d) : '0;
        vga_x_d      = pix_x_c;
        vga_y_d      = pix_y_c;
        vga_colour_d = job_d.colour;
        vga_plot_d   = (state_d == ST_DRAW) && on_screen_c;
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            last_q       <= IDX_LAST;
            job_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_q       <= last_d;
            job_q        <= job_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Scoreboard bench for sprite_plot_arbiter: a transaction-level round-robin model
// queues expected boxes and pixels; a negedge monitor checks plots and done pulses.
module tb_sprite_plot_arbiter;
    import sprite_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = DEF_SPRITE_W;
    localparam int unsigned H   = DEF_SPRITE_H;
    localparam int unsigned SW  = DEF_SCREEN_W;
    localparam int unsigned SH  = DEF_SCREEN_H;
    localparam int unsigned BOX = W * H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_plot_arbiter_if #(.N_REQ(N)) bus ();

    sprite_plot_arbiter #(
        .N_REQ(N), .SPRITE_W(W), .SPRITE_H(H), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int x; int y; int col; } pix_t;
    typedef struct { int idx; int n_plot; } job_t;

    pix_t pix_q[$];
    job_t job_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int mon_gcyc = 0;
    int mon_plots = 0;
    logic [N-1:0] prev_grant = '0;
    int grant_rise_cyc = 0;
    int done_cyc = 0;

    int m_last;
    int t_x[N], t_y[N], t_col[N], t_er[N], t_reps[N];
    int req_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every plotted pixel and every done pulse against the queues.
    always @(negedge clk) begin : monitor
        pix_t e;
        job_t j;
        if (!reset) begin
            if (bus.grant != '0) begin
                if (prev_grant == '0) grant_rise_cyc = cyc;
                mon_gcyc++;
            end
            prev_grant = bus.grant;
            if (bus.vga_plot) begin
                mon_plots++;
                if (pix_q.size() == 0 || job_q.size() == 0) begin
                    check("unexpected_plot", int'(bus.vga_plot), 0);
                end else begin
                    e = pix_q.pop_front();
                    check("pix_x", int'(bus.vga_x), e.x);
                    check("pix_y", int'(bus.vga_y), e.y);
                    check("pix_colour", int'(bus.vga_colour), e.col);
                    check("plot_grant", int'(bus.grant), 1 << job_q[0].idx);
                end
            end
            if (bus.done != '0) begin
                done_cyc = cyc;
                if (job_q.size() == 0) begin
                    check("unexpected_done", int'(bus.done), 0);
                end else begin
                    j = job_q.pop_front();
                    check("done_vec", int'(bus.done), 1 << j.idx);
                    check("draw_cycles", mon_gcyc, BOX);
                    check("plot_count", mon_plots, j.n_plot);
                    check("done_grant", int'(bus.grant), 0);
                end
                mon_gcyc  = 0;
                mon_plots = 0;
            end
        end
    end

    task automatic drive_fields();
        logic [8*N-1:0] vx;
        logic [7*N-1:0] vy;
        logic [3*N-1:0] vc;
        logic [N-1:0]   ve;
        vx = '0; vy = '0; vc = '0; ve = '0;
        for (int i = 0; i < N; i++) begin
            vx = vx | ((8*N)'(t_x[i]) << (8*i));
            vy = vy | ((7*N)'(t_y[i]) << (7*i));
            vc = vc | ((3*N)'(t_col[i]) << (3*i));
            ve = ve | (N'(t_er[i]) << i);
        end
        bus.req_x      = vx;
        bus.req_y      = vy;
        bus.req_colour = vc;
        bus.req_erase  = ve;
    endtask

    // Expected pixels of one box: row-major, wrapped coordinates, clipped to the screen.
    task automatic push_job(int i);
        job_t j;
        pix_t p;
        int n = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p.x   = (t_x[i] + c) % 256;
                p.y   = (t_y[i] + r) % 128;
                p.col = (t_er[i] != 0) ? 0 : t_col[i];
                if (p.x < SW && p.y < SH) begin
                    pix_q.push_back(p);
                    n++;
                end
            end
        end
        j.idx = i;
        j.n_plot = n;
        job_q.push_back(j);
    endtask

    // Queue the expected service order for a batch asserted together, then drive it.
    task automatic issue(logic [N-1:0] mask);
        int rem[N];
        bit any;
        for (int i = 0; i < N; i++) rem[i] = (((mask >> i) & N'(1)) != '0) ? t_reps[i] : 0;
        do begin
            any = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!any && rem[c] > 0) begin
                    push_job(c);
                    rem[c]--;
                    m_last = c;
                    any = 1'b1;
                end
            end
        end while (any);
        drive_fields();
        bus.req = mask;
        req_cyc = cyc;
    endtask

    // Requester behaviour: drop req after the last done; optionally disturb the winner's inputs.
    task automatic run_jobs(bit perturb);
        int dcnt[N];
        int budget = 0;
        int g;
        for (int i = 0; i < N; i++) dcnt[i] = 0;
        forever begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < N; i++) begin
                if (((bus.done >> i) & N'(1)) != '0) begin
                    dcnt[i]++;
                    if (dcnt[i] >= t_reps[i]) bus.req = bus.req & ~(N'(1) << i);
                end
            end
            if (perturb && bus.grant != '0 && $urandom_range(0, 15) == 0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (((bus.grant >> i) & N'(1)) != '0) g = i;
                if (t_reps[g] == 1) begin
                    t_x[g]   = $urandom_range(0, 255);
                    t_y[g]   = $urandom_range(0, 127);
                    t_col[g] = $urandom_range(0, 7);
                    t_er[g]  = $urandom_range(0, 1);
                    drive_fields();
                end
            end
            if (job_q.size() == 0 && !bus.busy && bus.req == '0) break;
            if (budget > 5000) begin
                check("timeout_jobs_left", job_q.size(), 0);
                job_q.delete();
                pix_q.delete();
                bus.req = '0;
                break;
            end
        end
    endtask

    task automatic set_req(int i, int x, int y, int col, int er);
        t_x[i] = x; t_y[i] = y; t_col[i] = col; t_er[i] = er; t_reps[i] = 1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.req = '0;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);
        drive_fields();
        m_last = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_plot", int'(bus.vga_plot), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_vga_x", int'(bus.vga_x), 0);
        check("rst_vga_y", int'(bus.vga_y), 0);
        check("rst_vga_colour", int'(bus.vga_colour), 0);
        reset = 1'b0;

        // All four held, each drops on its done: expected order 0,1,2,3.
        for (int i = 0; i < N; i++) set_req(i, 20 * i, 10 * i, i + 1, 0);
        issue(4'b1111);
        run_jobs(1'b0);

        // req[0] re-asserted after its done while req[1] pends: 0, 1, then 0.
        set_req(0, 5, 5, 2, 0);
        set_req(1, 60, 40, 6, 0);
        t_reps[0] = 2;
        issue(4'b0011);
        run_jobs(1'b0);
        t_reps[0] = 1;

        // Single requester with latency checks.
        set_req(0, 14, 0, 7, 0);
        issue(4'b0001);
        run_jobs(1'b0);
        check("single_grant_latency", grant_rise_cyc, req_cyc + 1);
        check("single_done_latency", done_cyc, req_cyc + 1 + BOX);

        // Erase draws black and only done[2] pulses.
        set_req(2, 40, 30, 5, 1);
        issue(4'b0100);
        run_jobs(1'b0);

        // Clipped box at the bottom-right corner keeps full timing.
        set_req(1, 155, 115, 3, 0);
        issue(4'b0010);
        run_jobs(1'b0);
        check("clip_grant_latency", grant_rise_cyc, req_cyc + 1);
        check("clip_done_latency", done_cyc, req_cyc + 1 + BOX);

        // Base x changed mid-draw is ignored.
        set_req(0, 14, 20, 4, 0);
        issue(4'b0001);
        while (cyc < req_cyc + 11) @(negedge clk);
        t_x[0] = 50;
        drive_fields();
        run_jobs(1'b0);

        // Reset at pixel 37 aborts the box with no done; pointer restarts at requester 0.
        set_req(0, 14, 0, 6, 0);
        issue(4'b0001);
        while (cyc < req_cyc + 38) @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1;
        pix_q.delete();
        job_q.delete();
        mon_gcyc = 0;
        mon_plots = 0;
        prev_grant = '0;
        m_last = N - 1;
        @(negedge clk);
        check("midrst_grant", int'(bus.grant), 0);
        check("midrst_plot", int'(bus.vga_plot), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        reset = 1'b0;
        set_req(1, 30, 60, 1, 0);
        set_req(2, 90, 70, 2, 0);
        issue(4'b0110);
        run_jobs(1'b0);

        // Randomized batches with wrap, clipping, repeats and mid-draw input changes.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++) begin
                t_x[i]    = $urandom_range(0, 255);
                t_y[i]    = $urandom_range(0, 127);
                t_col[i]  = $urandom_range(0, 7);
                t_er[i]   = ($urandom_range(0, 3) == 0) ? 1 : 0;
                t_reps[i] = $urandom_range(1, 2);
            end
            issue(N'($urandom_range(1, 15)));
            run_jobs(1'b1);
        end

        repeat (3) @(negedge clk);
        check("final_pix_queue", pix_q.size(), 0);
        check("final_job_queue", job_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
